mux_scan_ctrl: RTL and testbench

- Sequential select-line driver and capture stage wrapped around the existing 4-to-2 two-level mux. Drives the mux's `s1`/`s0`; its 1-bit `mux_in` is driven by that mux's `out`.
- Scans all four mux channels in order and waits a programmable settle time on each. Samples the mux output into a 4-bit frame.
- Presents the frame downstream on a valid/ready handshake.
- Supports single-shot and continuous scanning.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/scan_settle_timer.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 110 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux select scanner.
package mux_scan_pkg;

    localparam int unsigned NUM_CHAN = 4;
    localparam int unsigned CHAN_W   = 2;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } scan_state_e;

    // Channel k selects pair k[1] (s0) and the bit within it k[0] (s1); returns {s0, s1}.
    function automatic logic [1:0] chan_to_sel(input logic [CHAN_W-1:0] chan);
        return {chan[1], chan[0]};
    endfunction

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter used to hold each mux select for the settle window.
module scan_settle_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four channels of a 4-to-2 mux, captures a 4-bit frame and hands it off via valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          CONT_DEFAULT  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic                mux_in,
    output logic                s1,
    output logic                s0,
    output logic [NUM_CHAN-1:0] frame,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                busy
);

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [CHAN_W-1:0]   LastChan   = CHAN_W'(NUM_CHAN - 1);

    scan_state_e         state_d, state_q;
    logic [CHAN_W-1:0]   chan_d, chan_q;
    logic [NUM_CHAN-1:0] frame_d, frame_q;
    logic                valid_d, valid_q;
    logic                cont_d, cont_q;

    logic                handshake;
    logic                scan_begin;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [SETTLE_W-1:0] tmr_count;

    // Continuous flag is only re-sampled on the transfer edge.
    assign handshake  = (state_q == StDone) && frame_ready;
    assign cont_d     = handshake ? cont : cont_q;
    assign scan_begin = ((state_q == StIdle) && start) || (handshake && cont_d);

    scan_settle_timer #(
        .Width(SETTLE_W)
    ) u_settle_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (tmr_load),
        .load_val_i(SettleLoad),
        .dec_i     (tmr_dec),
        .count_o   (tmr_count),
        .zero_o    (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            chan_q  <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            cont_q  <= CONT_DEFAULT;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            cont_q  <= cont_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (tmr_zero) state_d = StSample;
            StSample: state_d = (chan_q == LastChan) ? StDone : StSettle;
            StDone:   if (frame_ready) state_d = cont_d ? StSettle : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        chan_d   = chan_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        tmr_dec  = (state_q == StSettle);
        if (scan_begin) begin
            chan_d   = '0;
            tmr_load = 1'b1;
        end
        if (state_q == StSample) begin
            frame_d[chan_q] = mux_in;
            if (chan_q == LastChan) begin
                valid_d = 1'b1;
            end else begin
                chan_d   = chan_q + CHAN_W'(1);
                tmr_load = 1'b1;
            end
        end
        if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        {s0, s1}    = chan_to_sel(chan_q);
        frame       = frame_q;
        frame_valid = valid_q;
        busy        = (state_q == StSettle) || (state_q == StSample);
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: three scanner instances (settle 1, 0, 15) each driving a behavioural 4-to-2 mux.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic       frame_ready;
    logic [1:0] in1, in2;
    int         which;

    logic       s1_a, s0_a, fv_a, busy_a, mux_a;
    logic       s1_b, s0_b, fv_b, busy_b, mux_b;
    logic       s1_c, s0_c, fv_c, busy_c, mux_c;
    logic [3:0] fr_a, fr_b, fr_c;
    logic       st_a, st_b, st_c;

    logic [1:0] obs_sel;
    logic [3:0] obs_frame;
    logic       obs_valid, obs_busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] in1;
        logic [1:0] in2;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[5];

    assign mux_a = s0_a ? in2[s1_a] : in1[s1_a];
    assign mux_b = s0_b ? in2[s1_b] : in1[s1_b];
    assign mux_c = s0_c ? in2[s1_c] : in1[s1_c];

    assign st_a = start && (which == 0);
    assign st_b = start && (which == 1);
    assign st_c = start && (which == 2);

    always_comb begin
        obs_sel   = {s0_a, s1_a};
        obs_frame = fr_a;
        obs_valid = fv_a;
        obs_busy  = busy_a;
        if (which == 1) begin
            obs_sel = {s0_b, s1_b}; obs_frame = fr_b; obs_valid = fv_b; obs_busy = busy_b;
        end else if (which == 2) begin
            obs_sel = {s0_c, s1_c}; obs_frame = fr_c; obs_valid = fv_c; obs_busy = busy_c;
        end
    end

    mux_scan_ctrl #(.SETTLE_CYCLES(1), .CONT_DEFAULT(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .start(st_a), .cont(cont), .mux_in(mux_a), .s1(s1_a), .s0(s0_a),
        .frame(fr_a), .frame_valid(fv_a), .frame_ready(frame_ready), .busy(busy_a)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(0), .CONT_DEFAULT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(st_b), .cont(cont), .mux_in(mux_b), .s1(s1_b), .s0(s0_b),
        .frame(fr_b), .frame_valid(fv_b), .frame_ready(frame_ready), .busy(busy_b)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(15), .CONT_DEFAULT(1'b0)) u_dut_c (
        .clk(clk), .rst(rst), .start(st_c), .cont(cont), .mux_in(mux_c), .s1(s1_c), .s0(s0_c),
        .frame(fr_c), .frame_valid(fv_c), .frame_ready(frame_ready), .busy(busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the selected DUT idle; returns #1 after the frame_valid edge.
    task automatic run_scan(input int settle, input logic [3:0] exp, input bit poke);
        int per;
        per   = settle + 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 4 * per; j++) begin
            check("scan_sel", 32'(obs_sel), 32'(j / per));
            check("scan_valid_low", 32'(obs_valid), 32'd0);
            check("scan_busy", 32'(obs_busy), 32'd1);
            start = poke && (j == per + 1);
            tick();
        end
        start = 1'b0;
        check("done_valid", 32'(obs_valid), 32'd1);
        check("done_frame", 32'(obs_frame), 32'(exp));
        check("done_sel", 32'(obs_sel), 32'd3);
        check("done_busy", 32'(obs_busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{in1: 2'b10, in2: 2'b01, exp: 4'b0110};
        vecs[1] = '{in1: 2'b11, in2: 2'b11, exp: 4'b1111};
        vecs[2] = '{in1: 2'b00, in2: 2'b00, exp: 4'b0000};
        vecs[3] = '{in1: 2'b01, in2: 2'b10, exp: 4'b1001};
        vecs[4] = '{in1: 2'b11, in2: 2'b00, exp: 4'b0011};

        which       = 0;
        rst         = 1'b1;
        start       = 1'b1;
        cont        = 1'b0;
        frame_ready = 1'b1;
        in1         = 2'b10;
        in2         = 2'b01;
        tick();
        // Reset held across an edge with start high: reset must win.
        check("rst_busy", 32'(obs_busy), 32'd0);
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_frame", 32'(obs_frame), 32'd0);
        check("rst_sel", 32'(obs_sel), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(obs_busy), 32'd0);

        // Table-driven single scans with ready held high; first one also pokes start mid-scan.
        for (int i = 0; i < 5; i++) begin
            in1 = vecs[i].in1;
            in2 = vecs[i].in2;
            run_scan(1, vecs[i].exp, i == 0);
            tick();
            check("xfer_valid_clr", 32'(obs_valid), 32'd0);
            check("xfer_idle", 32'(obs_busy), 32'd0);
            check("xfer_frame_kept", 32'(obs_frame), 32'(vecs[i].exp));
            tick();
            check("stay_idle", 32'(obs_busy), 32'd0);
        end

        // Backpressure: cont set during the scan but cleared before the handshake edge.
        in1         = 2'b10;
        in2         = 2'b01;
        frame_ready = 1'b0;
        cont        = 1'b1;
        run_scan(1, 4'b0110, 1'b1);
        cont = 1'b0;
        for (int j = 0; j < 20; j++) begin
            start = (j == 5);
            tick();
            check("bp_valid", 32'(obs_valid), 32'd1);
            check("bp_frame", 32'(obs_frame), 32'h6);
            check("bp_sel", 32'(obs_sel), 32'd3);
        end
        start       = 1'b0;
        frame_ready = 1'b1;
        tick();
        check("bp_valid_clr", 32'(obs_valid), 32'd0);
        check("bp_idle", 32'(obs_busy), 32'd0);
        tick();
        check("bp_no_rearm", 32'(obs_busy), 32'd0);

        // Continuous mode with zero settle: rescan starts on the handshake edge.
        which = 1;
        cont  = 1'b1;
        tick();
        run_scan(0, 4'b0110, 1'b0);
        in2 = 2'b11;
        tick();
        check("cont_restart_busy", 32'(obs_busy), 32'd1);
        check("cont_restart_sel", 32'(obs_sel), 32'd0);
        check("cont_valid_clr", 32'(obs_valid), 32'd0);
        cont = 1'b0;
        for (int j = 1; j < 8; j++) begin
            tick();
            check("cont_gap_valid", 32'(obs_valid), 32'd0);
            check("cont_gap_sel", 32'(obs_sel), 32'(j / 2));
        end
        tick();
        check("cont_f2_valid", 32'(obs_valid), 32'd1);
        check("cont_f2_frame", 32'(obs_frame), 32'he);
        tick();
        check("cont_end_idle", 32'(obs_busy), 32'd0);
        check("cont_end_valid", 32'(obs_valid), 32'd0);

        // Asynchronous reset during channel 2 settle.
        which = 0;
        in1   = 2'b11;
        in2   = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        check("pre_rst_sel", 32'(obs_sel), 32'd2);
        check("pre_rst_busy", 32'(obs_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_sel", 32'(obs_sel), 32'd0);
        check("arst_frame", 32'(obs_frame), 32'd0);
        check("arst_valid", 32'(obs_valid), 32'd0);
        check("arst_busy", 32'(obs_busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(obs_busy), 32'd0);
        run_scan(1, 4'b0111, 1'b0);
        tick();
        check("post_rst_xfer", 32'(obs_valid), 32'd0);

        // Maximum settle time.
        which = 2;
        in1   = 2'b11;
        in2   = 2'b11;
        tick();
        run_scan(15, 4'b1111, 1'b0);
        tick();
        check("s15_valid_clr", 32'(obs_valid), 32'd0);
        check("s15_idle", 32'(obs_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
